// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio SRAM record/playback sequencer.
package audio_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REC  = 3'd1,
    S_TREC = 3'd2,
    S_THRU = 3'd3,
    S_PLAY = 3'd4,
    S_PCAP = 3'd5
  } state_t;

  localparam logic [1:0] SPD_NORM = 2'b00;
  localparam logic [1:0] SPD_DBL  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_STOP = 3'd1,
    CMD_REC  = 3'd2,
    CMD_PLAY = 3'd3,
    CMD_THRU = 3'd4
  } cmd_t;

  // Highest priority first; bit k of cmd_decode's request vector maps to entry k.
  localparam cmd_t CMD_PRIO [4] = '{CMD_STOP, CMD_REC, CMD_PLAY, CMD_THRU};

  function automatic cmd_t cmd_decode(input logic [3:0] req);
    cmd_t sel;
    if (req[0]) begin
      sel = CMD_PRIO[0];
    end else if (req[1]) begin
      sel = CMD_PRIO[1];
    end else if (req[2]) begin
      sel = CMD_PRIO[2];
    end else if (req[3]) begin
      sel = CMD_PRIO[3];
    end else begin
      sel = CMD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/audio_frame_ptr.sv
// Frame pointer for record/playback: holds fp and the half-speed phase, and
// computes the speed-dependent advance and the end-of-recording compare.
module audio_frame_ptr
  import audio_seq_pkg::*;
#(
  parameter int FW = 19
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic          clr,
  input  logic          rec_inc,
  input  logic          play_adv,
  input  logic [1:0]    speed,
  input  logic          loop_en,
  input  logic [FW:0]   rec_len,
  output logic [FW-1:0] fp_idx,
  output logic [FW:0]   fp_inc,
  output logic          play_end
);

  logic [FW:0] fp_r;
  logic        phase_r;
  logic [FW:0] step_s;
  logic [FW:0] adv_fp_s;

  // Playback step per frame; half speed only moves on every second frame.
  always_comb begin
    step_s = {{FW{1'b0}}, 1'b1};
    case (speed)
      SPD_DBL: step_s = {{(FW-1){1'b0}}, 2'b10};
      SPD_HALF: begin
        if (phase_r) begin
          step_s = {{FW{1'b0}}, 1'b1};
        end else begin
          step_s = {(FW+1){1'b0}};
        end
      end
      default: step_s = {{FW{1'b0}}, 1'b1};
    endcase
  end

  assign adv_fp_s = fp_r + step_s;
  assign fp_inc   = fp_r + {{FW{1'b0}}, 1'b1};
  assign play_end = (adv_fp_s >= rec_len);
  assign fp_idx   = fp_r[FW-1:0];

  // Pointer and phase register; a loop wrap restarts both from frame 0.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      fp_r    <= {(FW+1){1'b0}};
      phase_r <= 1'b0;
    end else if (clr) begin
      fp_r    <= {(FW+1){1'b0}};
      phase_r <= 1'b0;
    end else if (rec_inc) begin
      fp_r    <= fp_inc;
      phase_r <= phase_r;
    end else if (play_adv) begin
      if (play_end && loop_en) begin
        fp_r    <= {(FW+1){1'b0}};
        phase_r <= 1'b0;
      end else begin
        fp_r    <= adv_fp_s;
        phase_r <= ~phase_r;
      end
    end else begin
      fp_r    <= fp_r;
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/audio_sram_sequencer.sv
// Stereo record/playback/pass-through sequencer between the codec front-end
// and the SRAM controller; left sample of frame fp lives at 2*fp, right at 2*fp+1.
module audio_sram_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 20,
  parameter int MAX_FRAMES = 2**(AW-1)
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic          stb_l,
  input  logic          stb_r,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  input  logic          cmd_rec,
  input  logic          cmd_play,
  input  logic          cmd_thru,
  input  logic          cmd_stop,
  input  logic [1:0]    speed,
  input  logic          loop_en,
  output logic          mem_cs_n,
  output logic          mem_we_n,
  output logic          mem_rd_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_l,
  output logic [DW-1:0] out_r,
  output logic [AW-1:0] rec_len,
  output logic          st_rec,
  output logic          st_play,
  output logic          st_thru
);

  localparam int FW = AW - 1;
  localparam logic [FW:0] MAX_F = MAX_FRAMES[FW:0];

  state_t        state_r, state_n_s, rec_exit_s;
  cmd_t          cmd_s;
  logic          stb_l_s, stb_r_s;
  logic          wr_s, rd_s;
  logic [AW-1:0] addr_s, addr_l_s, addr_r_s;
  logic [DW-1:0] wdata_s;
  logic          fp_clr_s, rec_inc_s, play_adv_s, rec_len_clr_s;
  logic          left_set_s, left_clr_s, left_done_r;
  logic          cap_wait_r, cap_right_r, cap_right_s;
  logic          load_l_s, load_r_s, cap_l_s, cap_r_s;
  logic [FW-1:0] fp_idx_s;
  logic [FW:0]   fp_inc_s;
  logic          play_end_s;

  logic          mem_cs_n_r, mem_we_n_r, mem_rd_n_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r, out_l_r, out_r_r;
  logic [FW:0]   rec_len_r;
  logic          st_rec_r, st_play_r, st_thru_r;

  audio_frame_ptr #(.FW(FW)) u_fp (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .clr      (fp_clr_s),
    .rec_inc  (rec_inc_s),
    .play_adv (play_adv_s),
    .speed    (speed),
    .loop_en  (loop_en),
    .rec_len  (rec_len_r),
    .fp_idx   (fp_idx_s),
    .fp_inc   (fp_inc_s),
    .play_end (play_end_s)
  );

  assign cmd_s      = cmd_decode({cmd_thru, cmd_play, cmd_rec, cmd_stop});
  assign stb_l_s    = stb_l;
  assign stb_r_s    = stb_r & ~stb_l;
  assign addr_l_s   = {fp_idx_s, 1'b0};
  assign addr_r_s   = {fp_idx_s, 1'b1};
  assign rec_exit_s = (state_r == S_TREC) ? S_THRU : S_IDLE;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_n_s     = state_r;
    wr_s          = 1'b0;
    rd_s          = 1'b0;
    addr_s        = mem_addr_r;
    wdata_s       = mem_wdata_r;
    fp_clr_s      = 1'b0;
    rec_inc_s     = 1'b0;
    play_adv_s    = 1'b0;
    rec_len_clr_s = 1'b0;
    left_set_s    = 1'b0;
    left_clr_s    = 1'b0;
    cap_right_s   = cap_right_r;
    load_l_s      = 1'b0;
    load_r_s      = 1'b0;
    cap_l_s       = 1'b0;
    cap_r_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        case (cmd_s)
          CMD_REC: begin
            fp_clr_s      = 1'b1;
            rec_len_clr_s = 1'b1;
            left_clr_s    = 1'b1;
            state_n_s     = S_REC;
          end
          CMD_PLAY: begin
            if (rec_len_r != {(FW+1){1'b0}}) begin
              fp_clr_s  = 1'b1;
              state_n_s = S_PLAY;
            end else begin
              state_n_s = S_IDLE;
            end
          end
          CMD_THRU: state_n_s = S_THRU;
          default:  state_n_s = S_IDLE;
        endcase
      end
      S_REC, S_TREC: begin
        if (state_r == S_TREC) begin
          load_l_s = stb_l_s;
          load_r_s = stb_r_s;
        end else begin
          load_l_s = 1'b0;
          load_r_s = 1'b0;
        end
        if (cmd_s == CMD_STOP) begin
          state_n_s = rec_exit_s;
        end else if (stb_l_s) begin
          wr_s       = 1'b1;
          addr_s     = addr_l_s;
          wdata_s    = in_l;
          left_set_s = 1'b1;
        end else if (stb_r_s && left_done_r) begin
          // Right write completes the frame; rec_len follows the advanced pointer.
          wr_s       = 1'b1;
          addr_s     = addr_r_s;
          wdata_s    = in_r;
          rec_inc_s  = 1'b1;
          left_clr_s = 1'b1;
          if (fp_inc_s == MAX_F) begin
            state_n_s = rec_exit_s;
          end else begin
            state_n_s = state_r;
          end
        end else begin
          state_n_s = state_r;
        end
      end
      S_THRU: begin
        load_l_s = stb_l_s;
        load_r_s = stb_r_s;
        if (cmd_s == CMD_STOP) begin
          state_n_s = S_IDLE;
        end else if (cmd_s == CMD_REC) begin
          fp_clr_s      = 1'b1;
          rec_len_clr_s = 1'b1;
          left_clr_s    = 1'b1;
          state_n_s     = S_TREC;
        end else begin
          state_n_s = S_THRU;
        end
      end
      S_PLAY: begin
        if (cmd_s == CMD_STOP) begin
          state_n_s = S_IDLE;
        end else if (stb_l_s) begin
          rd_s        = 1'b1;
          addr_s      = addr_l_s;
          cap_right_s = 1'b0;
          state_n_s   = S_PCAP;
        end else if (stb_r_s) begin
          rd_s        = 1'b1;
          addr_s      = addr_r_s;
          cap_right_s = 1'b1;
          state_n_s   = S_PCAP;
        end else begin
          state_n_s = S_PLAY;
        end
      end
      S_PCAP: begin
        // First cycle the strobe is on the bus; read data lands the cycle after.
        if (cmd_s == CMD_STOP) begin
          state_n_s = S_IDLE;
        end else if (cap_wait_r) begin
          state_n_s = S_PCAP;
        end else if (cap_right_r) begin
          cap_r_s    = 1'b1;
          play_adv_s = 1'b1;
          if (play_end_s && !loop_en) begin
            state_n_s = S_IDLE;
          end else begin
            state_n_s = S_PLAY;
          end
        end else begin
          cap_l_s   = 1'b1;
          state_n_s = S_PLAY;
        end
      end
      default: state_n_s = S_IDLE;
    endcase
  end

  // State, capture bookkeeping and recorded-length register.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state_r     <= S_IDLE;
      left_done_r <= 1'b0;
      cap_wait_r  <= 1'b0;
      cap_right_r <= 1'b0;
      rec_len_r   <= {(FW+1){1'b0}};
    end else begin
      state_r     <= state_n_s;
      cap_wait_r  <= rd_s;
      cap_right_r <= cap_right_s;
      if (left_clr_s) begin
        left_done_r <= 1'b0;
      end else if (left_set_s) begin
        left_done_r <= 1'b1;
      end else begin
        left_done_r <= left_done_r;
      end
      if (rec_len_clr_s) begin
        rec_len_r <= {(FW+1){1'b0}};
      end else if (rec_inc_s) begin
        rec_len_r <= fp_inc_s;
      end else begin
        rec_len_r <= rec_len_r;
      end
    end
  end

  // Registered SRAM port, DAC samples and status flags.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      mem_cs_n_r  <= 1'b1;
      mem_we_n_r  <= 1'b1;
      mem_rd_n_r  <= 1'b1;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      out_l_r     <= {DW{1'b0}};
      out_r_r     <= {DW{1'b0}};
      st_rec_r    <= 1'b0;
      st_play_r   <= 1'b0;
      st_thru_r   <= 1'b0;
    end else begin
      mem_cs_n_r  <= ~(wr_s | rd_s);
      mem_we_n_r  <= ~wr_s;
      mem_rd_n_r  <= ~rd_s;
      mem_addr_r  <= addr_s;
      mem_wdata_r <= wdata_s;
      if (load_l_s) begin
        out_l_r <= in_l;
      end else if (cap_l_s) begin
        out_l_r <= mem_rdata;
      end else begin
        out_l_r <= out_l_r;
      end
      if (load_r_s) begin
        out_r_r <= in_r;
      end else if (cap_r_s) begin
        out_r_r <= mem_rdata;
      end else begin
        out_r_r <= out_r_r;
      end
      st_rec_r  <= (state_n_s == S_REC)  || (state_n_s == S_TREC);
      st_play_r <= (state_n_s == S_PLAY) || (state_n_s == S_PCAP);
      st_thru_r <= (state_n_s == S_THRU) || (state_n_s == S_TREC);
    end
  end

  assign mem_cs_n  = mem_cs_n_r;
  assign mem_we_n  = mem_we_n_r;
  assign mem_rd_n  = mem_rd_n_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign out_l     = out_l_r;
  assign out_r     = out_r_r;
  assign rec_len   = rec_len_r;
  assign st_rec    = st_rec_r;
  assign st_play   = st_play_r;
  assign st_thru   = st_thru_r;

endmodule

// File: tb/tb_audio_sram_sequencer.sv
// Self-checking bench for audio_sram_sequencer with a small SRAM model and a
// frame-level record/playback reference model.
module tb_audio_sram_sequencer;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int MAXF = 8;

  logic          CLOCK_50 = 1'b0;
  logic          RST;
  logic          stb_l, stb_r;
  logic [DW-1:0] in_l, in_r;
  logic          cmd_rec, cmd_play, cmd_thru, cmd_stop;
  logic [1:0]    speed;
  logic          loop_en;
  logic          mem_cs_n, mem_we_n, mem_rd_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] out_l, out_r;
  logic [AW-1:0] rec_len;
  logic          st_rec, st_play, st_thru;

  int n_tests = 0;
  int n_fail  = 0;

  audio_sram_sequencer #(.DW(DW), .AW(AW)) dut (
    .CLOCK_50 (CLOCK_50), .RST (RST),
    .stb_l (stb_l), .stb_r (stb_r), .in_l (in_l), .in_r (in_r),
    .cmd_rec (cmd_rec), .cmd_play (cmd_play), .cmd_thru (cmd_thru), .cmd_stop (cmd_stop),
    .speed (speed), .loop_en (loop_en),
    .mem_cs_n (mem_cs_n), .mem_we_n (mem_we_n), .mem_rd_n (mem_rd_n),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
    .out_l (out_l), .out_r (out_r), .rec_len (rec_len),
    .st_rec (st_rec), .st_play (st_play), .st_thru (st_thru)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // SRAM model: registered read data, valid the cycle after the read strobe
  logic [DW-1:0] sram [16];
  always @(posedge CLOCK_50) begin
    if (!mem_cs_n && !mem_we_n) sram[mem_addr] <= mem_wdata;
    if (!mem_cs_n && !mem_rd_n) mem_rdata <= sram[mem_addr];
  end

  logic [AW+DW-1:0] wlog[$];
  always @(negedge CLOCK_50) begin
    if (!mem_cs_n && !mem_we_n) wlog.push_back({mem_addr, mem_wdata});
  end

  // Reference model of what has been recorded
  logic [DW-1:0]    exp_l [MAXF];
  logic [DW-1:0]    exp_r [MAXF];
  int               m_len;
  logic [AW+DW-1:0] exp_w[$];

  typedef struct {
    bit         from_thru;
    logic [3:0] cmds;    // {stop, rec, play, thru}
    logic [2:0] exp_st;  // {st_rec, st_play, st_thru}
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse_cmd(input logic [3:0] c);
    @(negedge CLOCK_50);
    {cmd_stop, cmd_rec, cmd_play, cmd_thru} = c;
    @(negedge CLOCK_50);
    {cmd_stop, cmd_rec, cmd_play, cmd_thru} = 4'b0000;
  endtask

  task automatic pulse_stb(input bit l, input bit r, input logic [DW-1:0] dl, input logic [DW-1:0] dr);
    @(negedge CLOCK_50);
    stb_l = l; stb_r = r; in_l = dl; in_r = dr;
    @(negedge CLOCK_50);
    stb_l = 1'b0; stb_r = 1'b0;
  endtask

  task automatic model_write(input int a, input logic [DW-1:0] d);
    logic [AW-1:0] aa;
    aa = AW'(a);
    exp_w.push_back({aa, d});
  endtask

  task automatic start_rec();
    pulse_cmd(4'b0100);
    m_len = 0;
  endtask

  task automatic rec_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pulse_stb(1'b1, 1'b0, l, '0);
    tick(1);
    pulse_stb(1'b0, 1'b1, '0, r);
    tick(1);
    if (m_len < MAXF) begin
      model_write(2*m_len, l);
      model_write(2*m_len+1, r);
      exp_l[m_len] = l;
      exp_r[m_len] = r;
      m_len++;
    end
  endtask

  task automatic check_writes(input string nm);
    check({nm, "_wcount"}, 32'(wlog.size()), 32'(exp_w.size()));
    for (int i = 0; i < wlog.size() && i < exp_w.size(); i++)
      check($sformatf("%s_w%0d", nm, i), 32'(wlog[i]), 32'(exp_w[i]));
    wlog.delete();
    exp_w.delete();
  endtask

  task automatic play_check(input logic [1:0] spd, input bit lp, input int extra, input string nm);
    int order[$];
    int n, f;
    if (spd == 2'b01) begin
      for (int k = 0; k < m_len; k += 2) order.push_back(k);
    end else if (spd == 2'b10) begin
      for (int k = 0; k < m_len; k++) begin order.push_back(k); order.push_back(k); end
    end else begin
      for (int k = 0; k < m_len; k++) order.push_back(k);
    end
    speed = spd;
    loop_en = lp;
    pulse_cmd(4'b0010);
    n = lp ? order.size() + extra : order.size();
    for (int k = 0; k < n; k++) begin
      f = order[k % order.size()];
      pulse_stb(1'b1, 1'b0, '0, '0);
      tick(3);
      check($sformatf("%s_k%0d_L", nm, k), 32'(out_l), 32'(exp_l[f]));
      pulse_stb(1'b0, 1'b1, '0, '0);
      tick(3);
      check($sformatf("%s_k%0d_R", nm, k), 32'(out_r), 32'(exp_r[f]));
    end
    if (lp) begin
      check({nm, "_loop_active"}, 32'(st_play), 32'd1);
      pulse_cmd(4'b1000);
    end
    check({nm, "_end_idle"}, 32'(st_play), 32'd0);
    loop_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a, b;
    int len;
    tbl[0] = '{1'b0, 4'b0100, 3'b100};
    tbl[1] = '{1'b0, 4'b0010, 3'b000};
    tbl[2] = '{1'b0, 4'b0001, 3'b001};
    tbl[3] = '{1'b0, 4'b1100, 3'b000};
    tbl[4] = '{1'b0, 4'b0111, 3'b100};
    tbl[5] = '{1'b1, 4'b1100, 3'b000};
    tbl[6] = '{1'b1, 4'b0100, 3'b101};
    tbl[7] = '{1'b1, 4'b0010, 3'b001};
    tbl[8] = '{1'b1, 4'b1000, 3'b000};
    tbl[9] = '{1'b0, 4'b0101, 3'b100};

    RST = 1'b0;
    stb_l = 1'b0; stb_r = 1'b0; in_l = '0; in_r = '0;
    {cmd_stop, cmd_rec, cmd_play, cmd_thru} = 4'b0000;
    speed = 2'b00; loop_en = 1'b0; m_len = 0;
    tick(3);
    check("rst_strobes", 32'({mem_cs_n, mem_we_n, mem_rd_n}), 32'b111);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_out", 32'({out_l, out_r}), 32'd0);
    check("rst_len", 32'(rec_len), 32'd0);
    check("rst_status", 32'({st_rec, st_play, st_thru}), 32'd0);
    RST = 1'b1;
    tick(2);

    // Command priority table, each vector from idle or pass-through
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].from_thru) pulse_cmd(4'b0001);
      pulse_cmd(tbl[i].cmds);
      check($sformatf("tbl%0d_status", i), 32'({st_rec, st_play, st_thru}), 32'(tbl[i].exp_st));
      pulse_cmd(4'b1000);
      pulse_cmd(4'b1000);
    end
    check_writes("tbl");
    check("tbl_len", 32'(rec_len), 32'd0);

    // Record four frames then play at normal speed
    start_rec();
    for (int n = 0; n < 4; n++) rec_frame(16'h1000 + 16'(n), 16'h2000 + 16'(n));
    pulse_cmd(4'b1000);
    check("rec4_len", 32'(rec_len), 32'd4);
    check("rec4_strec", 32'(st_rec), 32'd0);
    check_writes("rec4");
    play_check(2'b00, 1'b0, 0, "play4");

    // Early right ignored, simultaneous strobes keep only left, stop mid-frame
    start_rec();
    pulse_stb(1'b0, 1'b1, '0, 16'hBEEF);
    tick(1);
    pulse_stb(1'b1, 1'b1, 16'h1111, 16'h2222);
    tick(1);
    model_write(0, 16'h1111);
    pulse_stb(1'b0, 1'b1, '0, 16'h3333);
    tick(1);
    model_write(1, 16'h3333);
    exp_l[0] = 16'h1111; exp_r[0] = 16'h3333; m_len = 1;
    pulse_stb(1'b1, 1'b0, 16'h4444, '0);
    tick(1);
    model_write(2, 16'h4444);
    pulse_cmd(4'b1000);
    check("edge_len", 32'(rec_len), 32'd1);
    check_writes("edge");
    play_check(2'b00, 1'b0, 0, "edge_play");

    // Full memory: ten frames offered, eight kept
    start_rec();
    for (int i = 0; i < 10; i++) begin
      rec_frame(16'($urandom), 16'($urandom));
      check($sformatf("full_strec%0d", i), 32'(st_rec), (i < 7) ? 32'd1 : 32'd0);
    end
    check("full_len", 32'(rec_len), 32'd8);
    check_writes("full");
    play_check(2'b01, 1'b0, 0, "dbl");
    play_check(2'b01, 1'b1, 2, "dbl_loop");
    play_check(2'b11, 1'b0, 0, "spd11");

    // Half speed over three frames
    start_rec();
    for (int i = 0; i < 3; i++) rec_frame(16'($urandom), 16'($urandom));
    pulse_cmd(4'b1000);
    check("half_len", 32'(rec_len), 32'd3);
    check_writes("half");
    play_check(2'b10, 1'b0, 0, "half");

    // Randomized record lengths, speeds and loop settings
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, MAXF);
      start_rec();
      for (int i = 0; i < len; i++) rec_frame(16'($urandom), 16'($urandom));
      pulse_cmd(4'b1000);
      check($sformatf("rnd%0d_len", it), 32'(rec_len), 32'(len));
      check_writes($sformatf("rnd%0d", it));
      play_check(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), $sformatf("rnd%0d", it));
    end

    // Pass-through alone and while recording
    a = 16'($urandom); b = 16'($urandom);
    pulse_cmd(4'b0001);
    pulse_stb(1'b1, 1'b0, a, '0);
    tick(1);
    check("thru_l", 32'(out_l), 32'(a));
    pulse_stb(1'b0, 1'b1, '0, b);
    tick(1);
    check("thru_r", 32'(out_r), 32'(b));
    start_rec();
    rec_frame(b, a);
    check("trec_out", 32'({out_l, out_r}), 32'({b, a}));
    check("trec_status", 32'({st_rec, st_play, st_thru}), 32'b101);
    pulse_cmd(4'b1000);
    check("trec_stop", 32'({st_rec, st_play, st_thru}), 32'b001);
    pulse_cmd(4'b1000);
    check("trec_idle", 32'({st_rec, st_play, st_thru}), 32'b000);
    check("trec_len", 32'(rec_len), 32'd1);
    check_writes("trec");

    // Reset while a playback capture is pending
    speed = 2'b00;
    pulse_cmd(4'b0010);
    pulse_stb(1'b1, 1'b0, '0, '0);
    check("pcap_rd", 32'(mem_rd_n), 32'd0);
    RST = 1'b0;
    #1;
    check("mrst_strobes", 32'({mem_cs_n, mem_we_n, mem_rd_n}), 32'b111);
    check("mrst_out", 32'({out_l, out_r}), 32'd0);
    check("mrst_addr", 32'(mem_addr), 32'd0);
    check("mrst_len", 32'(rec_len), 32'd0);
    check("mrst_status", 32'({st_rec, st_play, st_thru}), 32'd0);
    @(negedge CLOCK_50);
    RST = 1'b1;
    tick(2);
    check("post_rst_status", 32'({st_rec, st_play, st_thru}), 32'd0);
    pulse_cmd(4'b0010);
    check("post_rst_play_ignored", 32'(st_play), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
